// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if
//   Bundles the receive-byte strobe, the instruction-memory write port and
//   the loader status outputs into one connection.
//   Parameter: ADDR_W - byte-address width of the memory write port.
//   Modports:
//     master - the loader (consumes start/rx/mem_ready, drives memory and status)
//     slave  - the environment (UART receiver, memory, boot control)
//
// Handshake semantics:
//   rx_valid is a one-cycle strobe with no back-pressure: a byte is consumed
//   on every rising edge where rx_valid=1.  The memory write is a valid/ready
//   pair: mem_we (valid) stays high with mem_addr/mem_wdata stable until the
//   edge where mem_ready=1; that edge is the single transfer of the word.
interface uart_program_loader_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              ld_done;
  logic              ld_error;
  logic [2:0]        err_code;
  logic [15:0]       words_loaded;

  modport master (
    input  start, rx_valid, rx_data, mem_ready,
    output mem_we, mem_addr, mem_wdata, busy, ld_done, ld_error, err_code,
           words_loaded
  );

  modport slave (
    output start, rx_valid, rx_data, mem_ready,
    input  mem_we, mem_addr, mem_wdata, busy, ld_done, ld_error, err_code,
           words_loaded
  );
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Boot-time loader: receives a length-prefixed byte stream (LEN_LO, LEN_HI,
//   then LEN*4 little-endian data bytes), packs it into 32-bit words and
//   writes them sequentially to instruction memory from BASE_ADDR.  Raises
//   ld_done on success or ld_error with err_code on failure
//   (1 length too big, 2 timeout, 3 rx overrun, 4 checksum).
//   Optional feature macro: LOADER_CHECKSUM_EN - when defined, a trailer byte
//   equal to the XOR of all data bytes must follow the last word.
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-low reset
//   bus         - uart_program_loader_if.master (rx byte in, memory write
//                 port out, status out)
//   dbg_state_o - current FSM state encoding, for observation only
module uart_program_loader #(
  parameter int ADDR_W         = 12,
  parameter int BASE_ADDR      = 0,
  parameter int MAX_WORDS      = 1000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_program_loader_if.master bus,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Where the FSM goes once every word has been committed.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CSUM;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     words_q, words_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic [2:0]      err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [16:0]     len_full;
  logic            tmo_expired;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  // Length as it will be once the LEN_HI byte is taken.
  assign len_full    = {1'b0, bus.rx_data, len_q[7:0]};
  assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      words_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      err_q   <= '0;
      tmo_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    idx_d   = idx_q;
    word_d  = word_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    // Inter-byte timer only runs while waiting on the UART; a byte always
    // reloads it, even on the cycle it would otherwise expire.
    if (state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM}) begin
      tmo_d = bus.rx_valid ? '0 : tmo_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_d = S_LEN_LO;
          words_d = '0;
          err_d   = '0;
          idx_d   = '0;
          tmo_d   = '0;
          len_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (bus.rx_valid) begin
          len_d[7:0] = bus.rx_data;
          state_d    = S_LEN_HI;
        end else if (tmo_expired) begin
          state_d = S_ERROR;
          err_d   = 3'd2;
        end
      end
      S_LEN_HI: begin
        if (bus.rx_valid) begin
          len_d = len_full[15:0];
          if (len_full > 17'(MAX_WORDS)) begin
            state_d = S_ERROR;
            err_d   = 3'd1;
          end else if (len_full == 17'd0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_DATA;
          end
        end else if (tmo_expired) begin
          state_d = S_ERROR;
          err_d   = 3'd2;
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          // Shift in from the top so the first byte ends up in [7:0].
          word_d = {bus.rx_data, word_q[31:8]};
          idx_d  = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.rx_data;
`endif
          if (idx_q == 2'd3) state_d = S_WRITE;
        end else if (tmo_expired) begin
          state_d = S_ERROR;
          err_d   = 3'd2;
        end
      end
      S_WRITE: begin
        // A handshake completing on the same edge still counts as committed.
        if (bus.mem_ready) words_d = words_q + 16'd1;
        if (bus.rx_valid) begin
          state_d = S_ERROR;
          err_d   = 3'd3;
        end else if (bus.mem_ready) begin
          state_d = ((words_q + 16'd1) == len_q) ? S_FINISH : S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
            err_d   = 3'd4;
          end
        end else if (tmo_expired) begin
          state_d = S_ERROR;
          err_d   = 3'd2;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_we       = (state_q == S_WRITE);
  assign bus.mem_addr     = ADDR_W'(BASE_ADDR) + ADDR_W'({words_q, 2'b00});
  assign bus.mem_wdata    = word_q;
  assign bus.busy         = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM};
  assign bus.ld_done      = (state_q == S_DONE);
  assign bus.ld_error     = (state_q == S_ERROR);
  assign bus.err_code     = err_q;
  assign bus.words_loaded = words_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader
//   Directed bench for uart_program_loader.  A stream-level model turns each
//   byte stream into the list of (address, word) writes it must produce; a
//   negedge monitor checks every accepted write against that list and checks
//   that a stalled write keeps address/data stable.  Final status is checked
//   after each load, and a few literal words pin the model.
module tb_uart_program_loader;
  localparam int ADDR_W         = 12;
  localparam int BASE_ADDR      = 0;
  localparam int MAX_WORDS      = 1000;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int WW             = ADDR_W + 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;

  uart_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_program_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR),
    .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, state=%0d", dbg_state);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] wr_log[$];
  logic [7:0]    stream_q[$];
  logic [WW-1:0] cur_wr;
  logic [WW-1:0] prev_wr = '0;
  logic          prev_we = 1'b0;
  logic          prev_acc = 1'b0;

  assign cur_wr = {bus.mem_addr, bus.mem_wdata};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every accepted word must be the next one the model expects.
  always @(negedge clk) begin
    if (rst && bus.mem_we) begin
      if (prev_we && !prev_acc) chk("wr_stable", 64'(cur_wr), 64'(prev_wr));
      if (bus.mem_ready) begin
        wr_log.push_back(cur_wr);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got 0x%0h expected no write", cur_wr);
        end else begin
          chk("wr_word", 64'(cur_wr), 64'(exp_q.pop_front()));
        end
      end
    end
    prev_we  <= rst && bus.mem_we;
    prev_acc <= bus.mem_ready;
    prev_wr  <= cur_wr;
  end

  // Stream-level model: length prefix, then little-endian words at BASE+4*i.
  task automatic model_load();
    int len;
    logic [31:0] w;
    len = {stream_q[1], stream_q[0]};
    if (len > MAX_WORDS) return;
    for (int i = 0; i < len; i++) begin
      w = {stream_q[2+4*i+3], stream_q[2+4*i+2], stream_q[2+4*i+1], stream_q[2+4*i]};
      exp_q.push_back({ADDR_W'(BASE_ADDR + 4*i), w});
    end
  endtask

  task automatic append_trailer();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < stream_q.size(); i++) x ^= stream_q[i];
    stream_q.push_back(x);
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
    ticks(gap);
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(stream_q[i], 2);
  endtask

  task automatic set_stream(input logic [7:0] b[]);
    stream_q.delete();
    foreach (b[i]) stream_q.push_back(b[i]);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy) break;
      tick();
    end
    chk("wait_idle", 64'(bus.busy), 64'(0));
  endtask

  task automatic check_end(input logic d, input logic e, input logic [2:0] c,
                           input logic [15:0] w);
    chk("ld_done", 64'(bus.ld_done), 64'(d));
    chk("ld_error", 64'(bus.ld_error), 64'(e));
    chk("err_code", 64'(bus.err_code), 64'(c));
    chk("words_loaded", 64'(bus.words_loaded), 64'(w));
    chk("busy_end", 64'(bus.busy), 64'(0));
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_ld_done", 64'(bus.ld_done), 64'(0));
    chk("rst_ld_error", 64'(bus.ld_error), 64'(0));
    chk("rst_err_code", 64'(bus.err_code), 64'(0));
    chk("rst_words", 64'(bus.words_loaded), 64'(0));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bus.start     = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.mem_ready = 1'b1;
    rst = 1'b0;
    ticks(3);
    check_reset_outputs();
    rst = 1'b1;
    tick();

    // 1: two-word load, memory always ready
    set_stream('{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    append_trailer();
    model_load();
    wr_log.delete();
    do_start();
    chk("t1_busy", 64'(bus.busy), 64'(1));
    send_range(0, stream_q.size() - 1);
    wait_idle(20);
    check_end(1'b1, 1'b0, 3'd0, 16'd2);
    chk("t1_nwrites", 64'(wr_log.size()), 64'(2));
    if (wr_log.size() == 2) begin
      chk("t1_word0", 64'(wr_log[0]), 64'({12'h000, 32'h12345678}));
      chk("t1_word1", 64'(wr_log[1]), 64'({12'h004, 32'hDEADBEEF}));
    end
    // stray byte after DONE is ignored
    send_byte(8'hAA, 2);
    chk("t1_done_hold", 64'(bus.ld_done), 64'(1));
    chk("t1_words_hold", 64'(bus.words_loaded), 64'(2));

    // 2: memory stalls on word 0; start while busy is ignored
    set_stream('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    append_trailer();
    model_load();
    wr_log.delete();
    bus.mem_ready = 1'b0;
    do_start();
    send_range(0, 4);
    send_byte(stream_q[5], 0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_we_held", 64'(bus.mem_we), 64'(1));
      chk("t2_no_commit", 64'(bus.words_loaded), 64'(0));
      if (i == 2) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
      end else if (i < 4) begin
        tick();
      end
    end
    bus.mem_ready = 1'b1;
    tick();
    if (stream_q.size() > 6) send_range(6, stream_q.size() - 1);
    wait_idle(20);
    check_end(1'b1, 1'b0, 3'd0, 16'd1);
    chk("t2_nwrites", 64'(wr_log.size()), 64'(1));
    if (wr_log.size() == 1) chk("t2_word0", 64'(wr_log[0]), 64'({12'h000, 32'hDDCCBBAA}));

    // 3a: zero-length program
    set_stream('{8'h00, 8'h00});
    append_trailer();
    wr_log.delete();
    do_start();
    send_range(0, stream_q.size() - 1);
    wait_idle(20);
    check_end(1'b1, 1'b0, 3'd0, 16'd0);
    chk("t3_nwrites", 64'(wr_log.size()), 64'(0));

    // 3b: length exactly MAX_WORDS is accepted (abort with reset afterwards)
    do_start();
    send_byte(8'hE8, 2);
    send_byte(8'h03, 2);
    chk("t3_max_busy", 64'(bus.busy), 64'(1));
    chk("t3_max_noerr", 64'(bus.ld_error), 64'(0));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // 3c: length MAX_WORDS+1 rejected
    do_start();
    send_byte(8'hE9, 2);
    send_byte(8'h03, 2);
    check_end(1'b0, 1'b1, 3'd1, 16'd0);

    // 4: timeout mid-word, exactly TIMEOUT_CYCLES silent cycles
    do_start();
    send_byte(8'h02, 2);
    send_byte(8'h00, 2);
    send_byte(8'h78, 2);
    send_byte(8'h56, 0);
    ticks(TIMEOUT_CYCLES - 1);
    chk("t4_not_yet", 64'(bus.ld_error), 64'(0));
    chk("t4_still_busy", 64'(bus.busy), 64'(1));
    tick();
    check_end(1'b0, 1'b1, 3'd2, 16'd0);

`ifdef LOADER_CHECKSUM_EN
    // 5: checksum trailer good / bad
    set_stream('{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F});
    model_load();
    wr_log.delete();
    do_start();
    send_range(0, 6);
    wait_idle(20);
    check_end(1'b1, 1'b0, 3'd0, 16'd1);
    if (wr_log.size() == 1) chk("t5_word0", 64'(wr_log[0]), 64'({12'h000, 32'h08040201}));
    set_stream('{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E});
    model_load();
    do_start();
    send_range(0, 6);
    wait_idle(20);
    check_end(1'b0, 1'b1, 3'd4, 16'd1);
`endif

    // 6: reset in the middle of word 1 of 3, then a clean reload
    set_stream('{8'h03, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B});
    append_trailer();
    model_load();
    do_start();
    send_range(0, 7);
    chk("t6_words_before", 64'(bus.words_loaded), 64'(1));
    rst = 1'b0;
    tick();
    exp_q.delete();
    check_reset_outputs();
    ticks(2);
    check_reset_outputs();
    rst = 1'b1;
    tick();
    model_load();
    wr_log.delete();
    do_start();
    send_range(0, stream_q.size() - 1);
    wait_idle(20);
    check_end(1'b1, 1'b0, 3'd0, 16'd3);
    if (wr_log.size() == 3) chk("t6_word2", 64'(wr_log[2]), 64'({12'h008, 32'h0B0A0908}));

    // 7: byte arrives while a write is pending -> overrun
    set_stream('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    bus.mem_ready = 1'b0;
    do_start();
    send_range(0, 5);
    chk("t7_in_write", 64'(bus.mem_we), 64'(1));
    send_byte(8'h55, 0);
    bus.mem_ready = 1'b1;
    ticks(3);
    check_end(1'b0, 1'b1, 3'd3, 16'd0);
    chk("t7_we_off", 64'(bus.mem_we), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
